// File: rtl/pin_entry_collector.sv
// Keypad PIN collector: shifts BCD digits into a buffer, handles BACK/CLEAR/ENTER
// and discards a partial entry after an inactivity timeout.
//
// state   | meaning
// IDLE    | no digits held
// COLLECT | 1..DIGITS digits held, inactivity timer running
// LOAD    | single cycle with pin_load high, buffer presented downstream
module pin_entry_collector #(
    parameter int DIGITS         = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    output logic [4*DIGITS-1:0]           pin_bcd,
    output logic                          pin_load,
    output logic [$clog2(DIGITS+1)-1:0]   digit_count,
    output logic                          entry_error,
    output logic                          busy
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_LOAD    = 2'd2;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_BACK  = 4'hC;

    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]          state_q, state_d;
    logic [4*DIGITS-1:0] buf_q, buf_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic                err_q, err_d;
    logic                load_q;
    logic                busy_q;
    logic                timeout;

    // Timer reloads on every key (accepted or not) and outside COLLECT,
    // so expiry only fires on a cycle with no key.
    assign timeout = (state_q == ST_COLLECT) && !key_valid && (tmr_q == '0);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (key_valid) begin
                    if (key_code <= 4'd9) begin
                        if (cnt_q < CNT_FULL) begin
                            buf_d   = {buf_q[4*DIGITS-5:0], key_code};
                            cnt_d   = cnt_q + 1'b1;
                            state_d = ST_COLLECT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        case (key_code)
                            KEY_CLEAR: begin
                                buf_d   = '0;
                                cnt_d   = '0;
                                state_d = ST_IDLE;
                            end
                            KEY_ENTER: begin
                                if (cnt_q == CNT_FULL) state_d = ST_LOAD;
                                else                   err_d   = 1'b1;
                            end
                            KEY_BACK: begin
                                if (cnt_q != '0) begin
                                    buf_d = buf_q >> 4;
                                    cnt_d = cnt_q - 1'b1;
                                    if (cnt_q == CNT_ONE) state_d = ST_IDLE;
                                end
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end else if (timeout) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_LOAD: begin
                buf_d   = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
                err_d   = key_valid;
            end
            default: begin
                buf_d   = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tmr_d = TMR_LOAD;
        if ((state_q == ST_COLLECT) && !key_valid && (tmr_q != '0)) tmr_d = tmr_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= TMR_LOAD;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            load_q  <= (state_d == ST_LOAD);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign pin_bcd     = buf_q;
    assign pin_load    = load_q;
    assign digit_count = cnt_q;
    assign entry_error = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pin_entry_collector.sv
// Directed bench for pin_entry_collector: a queue-based entry model checked every
// cycle, plus literal expectations along the test sequence.
module tb_pin_entry_collector;

    localparam int D = 4;
    localparam int T = 8;

    logic          clk;
    logic          rst;
    logic          key_valid;
    logic [3:0]    key_code;
    logic [4*D-1:0] pin_bcd;
    logic          pin_load;
    logic [2:0]    digit_count;
    logic          entry_error;
    logic          busy;

    int checks_total = 0;
    int checks_pass  = 0;

    pin_entry_collector #(.DIGITS(D), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .rst(rst),
        .key_valid(key_valid),
        .key_code(key_code),
        .pin_bcd(pin_bcd),
        .pin_load(pin_load),
        .digit_count(digit_count),
        .entry_error(entry_error),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: the entry is a list of digits; the timer is "edges since last key".
    int  m_digits[$];
    bit  m_load;
    bit  m_err;
    int  m_idle;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_digits.delete();
            m_load = 0;
            m_err  = 0;
            m_idle = 0;
        end else begin
            m_err = 0;
            if (m_load) begin
                m_load = 0;
                m_digits.delete();
                m_idle = 0;
                if (key_valid) m_err = 1;
            end else if (key_valid) begin
                m_idle = 0;
                if (key_code <= 9) begin
                    if (m_digits.size() < D) m_digits.push_back(int'(key_code));
                    else m_err = 1;
                end else if (key_code == 4'hA) begin
                    m_digits.delete();
                end else if (key_code == 4'hB) begin
                    if (m_digits.size() == D) m_load = 1;
                    else m_err = 1;
                end else if (key_code == 4'hC) begin
                    if (m_digits.size() > 0) void'(m_digits.pop_back());
                end else begin
                    m_err = 1;
                end
            end else if (m_digits.size() > 0) begin
                m_idle++;
                if (m_idle == T) begin
                    m_digits.delete();
                    m_err  = 1;
                    m_idle = 0;
                end
            end else begin
                m_idle = 0;
            end
        end
    end

    function automatic logic [4*D-1:0] model_bcd();
        logic [4*D-1:0] v = '0;
        foreach (m_digits[i]) v = (v << 4) | (4*D)'(m_digits[i]);
        return v;
    endfunction

    always @(negedge clk) begin
        check("pin_bcd",     32'(pin_bcd),     32'(model_bcd()));
        check("digit_count", 32'(digit_count), 32'(m_digits.size()));
        check("pin_load",    32'(pin_load),    32'(m_load));
        check("entry_error", 32'(entry_error), 32'(m_err));
        check("busy",        32'(busy),        32'(m_load || m_digits.size() > 0));
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst       = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        #2;
        check("rst_bcd",  32'(pin_bcd),     32'h0);
        check("rst_cnt",  32'(digit_count), 32'h0);
        check("rst_busy", 32'(busy),        32'h0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // full entry and load
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hB);
        check("t1_load", 32'(pin_load), 32'h1);
        check("t1_bcd",  32'(pin_bcd),  32'h1234);
        wait_cyc(1);
        check("t1_load_end", 32'(pin_load), 32'h0);
        check("t1_clr_bcd",  32'(pin_bcd),  32'h0);
        check("t1_busy",     32'(busy),     32'h0);

        // backspace inside an entry, then backspace from empty
        press(4'h5); press(4'h6); press(4'h7); press(4'hC); press(4'h8); press(4'h9); press(4'hB);
        check("t2_load", 32'(pin_load), 32'h1);
        check("t2_bcd",  32'(pin_bcd),  32'h5689);
        wait_cyc(1);
        press(4'hC);
        check("t2_back0_err", 32'(entry_error), 32'h0);
        check("t2_back0_cnt", 32'(digit_count), 32'h0);

        // short ENTER, then overflow digit
        press(4'h1); press(4'h2); press(4'hB);
        check("t3_short_err",  32'(entry_error), 32'h1);
        check("t3_short_load", 32'(pin_load),    32'h0);
        check("t3_short_bcd",  32'(pin_bcd),     32'h0012);
        press(4'hA);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        check("t3_ovf_err", 32'(entry_error), 32'h1);
        check("t3_ovf_bcd", 32'(pin_bcd),     32'h1234);
        press(4'hA);
        check("t3_clr_err", 32'(entry_error), 32'h0);

        // invalid code, key during LOAD, CLEAR
        press(4'hE);
        check("t4_inv_err", 32'(entry_error), 32'h1);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hB); press(4'h7);
        check("t4_load_key_err", 32'(entry_error), 32'h1);
        check("t4_load_key_bcd", 32'(pin_bcd),     32'h0);
        press(4'h9); press(4'h9);
        check("t4_99", 32'(pin_bcd), 32'h0099);
        press(4'hA);
        check("t4_clr_bcd", 32'(pin_bcd),     32'h0);
        check("t4_clr_err", 32'(entry_error), 32'h0);

        // timeout after exactly T idle cycles
        press(4'h3);
        wait_cyc(T - 1);
        check("t5_pre_err", 32'(entry_error), 32'h0);
        check("t5_pre_cnt", 32'(digit_count), 32'h1);
        wait_cyc(1);
        check("t5_to_err", 32'(entry_error), 32'h1);
        check("t5_to_bcd", 32'(pin_bcd),     32'h0);
        wait_cyc(1);
        check("t5_to_pulse", 32'(entry_error), 32'h0);

        // key on the expiry cycle wins
        press(4'h3);
        wait_cyc(T - 1);
        press(4'h4);
        check("t5_win_err", 32'(entry_error), 32'h0);
        check("t5_win_cnt", 32'(digit_count), 32'h2);
        check("t5_win_bcd", 32'(pin_bcd),     32'h0034);
        press(4'hA);

        // asynchronous reset mid-entry
        press(4'h1); press(4'h2); press(4'h3);
        #3 rst = 1'b0;
        #1;
        check("t6_rst_bcd",  32'(pin_bcd),     32'h0);
        check("t6_rst_cnt",  32'(digit_count), 32'h0);
        check("t6_rst_busy", 32'(busy),        32'h0);
        check("t6_rst_err",  32'(entry_error), 32'h0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        press(4'h4); press(4'h3); press(4'h2); press(4'h1); press(4'hB);
        check("t6_load", 32'(pin_load), 32'h1);
        check("t6_bcd",  32'(pin_bcd),  32'h4321);
        wait_cyc(1);

        // asynchronous reset during LOAD
        press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'hB);
        #2 rst = 1'b0;
        #1;
        check("t7_rst_load", 32'(pin_load), 32'h0);
        check("t7_rst_bcd",  32'(pin_bcd),  32'h0);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        check("t7_no_load", 32'(pin_load), 32'h0);
        wait_cyc(2);

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule

// File: doc/pin_entry_collector.md
# pin_entry_collector

Collects decimal PIN digits from the keypad decoder, one `key_valid` pulse per key, into a BCD shift buffer. Supports backspace, clear, enter and an inactivity timeout. On a valid ENTER it presents the complete PIN with a one-cycle `pin_load` strobe. This block sits directly upstream of the PIN holding register: `pin_bcd` drives that register's `data_in` and `pin_load` drives its `en`.

## Interface
Parameters:
- `DIGITS`, 4: PIN length in decimal digits (≥2).
- `TIMEOUT_CYCLES`, 1000: idle cycles after which a partial entry is discarded (≥2).

Ports:
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low (0 = reset).
- `key_valid`, in, 1: single-cycle strobe; `key_code` is valid while it is high.
- `key_code`, in, 4: 0x0–0x9 digit; 0xA CLEAR; 0xB ENTER; 0xC BACK; 0xD–0xF invalid.
- `pin_bcd`, out, 4*DIGITS: digit buffer; the first-entered digit is in the MS nibble once full.
- `pin_load`, out, 1: one-cycle strobe; `pin_bcd` holds the complete PIN while it is high.
- `digit_count`, out, $clog2(DIGITS+1): number of digits currently held.
- `entry_error`, out, 1: one-cycle strobe on a rejected key or a timeout.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: `digit_count`=0.
  - COLLECT: 1 ≤ `digit_count` ≤ DIGITS.
  - LOAD: the single cycle in which `pin_load` is high.
- Digit key:
  - If count < DIGITS: `pin_bcd` ← {`pin_bcd`[4*DIGITS-5:0], `key_code`}, count+1, IDLE→COLLECT.
  - If count = DIGITS: key dropped, `entry_error` pulses, buffer unchanged.
- ENTER:
  - If count = DIGITS: go to LOAD. In LOAD, `pin_load`=1 and `pin_bcd` is unchanged.
  - In the next cycle, `pin_bcd`←0, count←0, state←IDLE.
  - If count < DIGITS (including 0): `entry_error` pulses; buffer, count and state are unchanged.
- BACK:
  - If count > 0: `pin_bcd` ← `pin_bcd` >> 4 (zero fill), count−1; COLLECT→IDLE when count reaches 0.
  - If count = 0: no-op, no error.
- CLEAR: `pin_bcd`←0, count←0, state←IDLE, no error. This applies from any state except LOAD.
- Invalid codes 0xD–0xF: dropped, `entry_error` pulses.
- Keys in LOAD: dropped, `entry_error` pulses. LOAD always proceeds to IDLE.
- Timeout counter:
  - Counts only in COLLECT.
  - Zeroed by any `key_valid` (including rejected keys) and whenever the state is not COLLECT.
  - When it reaches TIMEOUT_CYCLES: buffer and count are cleared, state←IDLE, `entry_error` pulses.
- Buffer nibbles hold only 0–9; no other value is ever written.

## Timing
- Reset (`rst`=0, asynchronous): `pin_bcd`=0, `pin_load`=0, `digit_count`=0, `entry_error`=0, `busy`=0, state IDLE, timer 0. Outputs are valid immediately, independent of `clk`.
- All outputs are registered.
- Latency: a key sampled at edge N is reflected in `pin_bcd`/`digit_count`/`entry_error` after edge N.
- ENTER at edge N (count = DIGITS): `pin_load`=1 for the cycle N→N+1; buffer cleared after edge N+1.
- Timeout: with the last key sampled at edge N, `entry_error` asserts after edge N+TIMEOUT_CYCLES, and the clear happens at that same edge.
- `key_valid` in the same cycle the timer would expire: the key wins. It is processed normally and the timer restarts.
- Back-to-back `key_valid` on consecutive cycles: every key is processed; there is no throughput limit except in LOAD.
- Reset asserted mid-entry or during LOAD: immediate return to the reset values. No `pin_load` is emitted afterwards.

## Test plan
- Reset, then digits 1,2,3,4 and ENTER on consecutive cycles → `pin_bcd`=0x1234 and `pin_load`=1 for exactly one cycle; next cycle `pin_bcd`=0, `digit_count`=0, `busy`=0.
- Digits 5,6,7, BACK, 8, 9, ENTER → `pin_bcd`=0x5689 during `pin_load`; BACK from count 0 produces no `entry_error`.
- Digits 1,2 then ENTER → one `entry_error` pulse, no `pin_load`, `pin_bcd`=0x0012 retained. A fifth digit after 1,2,3,4 → `entry_error`, `pin_bcd` stays 0x1234.
- Key 0xE, and a key sampled during LOAD → `entry_error` pulse for each, buffer unaffected. CLEAR after 9,9 → `pin_bcd`=0, no error.
- TIMEOUT_CYCLES=8: digit 3, then idle → `entry_error` after exactly 8 idle cycles and `pin_bcd`=0. Repeat with a key arriving on cycle 8 → no timeout, `digit_count`=2.
- Drive `rst`=0 asynchronously, between clock edges, while count=3 → all outputs 0 immediately; after release, a full 4-digit entry loads correctly.
